// File: rtl/apb_master_8bit_if.sv
// Command/response and APB bus signals of the 8-bit APB initiator.
// The master modport is the initiator's view; slave is the requester/peripheral side.
interface apb_master_8bit_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 3
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_slverr;
    logic                  rsp_timeout;
    logic                  busy;
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pready;
    logic                  pslverr;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready, pslverr,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout, busy,
        output psel, penable, pwrite, paddr, pwdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready, pslverr,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout, busy,
        input  psel, penable, pwrite, paddr, pwdata
    );
endinterface

// File: rtl/apb_master_8bit.sv
// APB initiator: turns single-beat commands into SETUP/ACCESS transfers and reports
// read data, slave error and timeout for each one.
module apb_master_8bit #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned TIMEOUT    = 16
) (
    input logic                pclk,
    input logic                preset,
    apb_master_8bit_if.master  bus
);
    // Keep at least one bit so TIMEOUT = 0 still elaborates.
    localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

    state_e                state_q;
    logic [CNT_W-1:0]      wait_q;
    logic                  psel_q;
    logic                  penable_q;
    logic                  pwrite_q;
    logic [ADDR_WIDTH-1:0] paddr_q;
    logic [DATA_WIDTH-1:0] pwdata_q;
    logic                  rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;
    logic                  rsp_slverr_q;
    logic                  rsp_timeout_q;
    logic                  busy_q;
    logic                  accept;
    logic                  timeout_hit;

    assign bus.cmd_ready   = (state_q == StIdle) && !preset;
    assign accept          = bus.cmd_valid && (state_q == StIdle);
    assign timeout_hit     = (TIMEOUT != 0) && (wait_q == CNT_MAX);

    assign bus.psel        = psel_q;
    assign bus.penable     = penable_q;
    assign bus.pwrite      = pwrite_q;
    assign bus.paddr       = paddr_q;
    assign bus.pwdata      = pwdata_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_slverr  = rsp_slverr_q;
    assign bus.rsp_timeout = rsp_timeout_q;
    assign bus.busy        = busy_q;

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q       <= StIdle;
            wait_q        <= '0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_slverr_q  <= 1'b0;
            rsp_timeout_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        pwrite_q <= bus.cmd_write;
                        paddr_q  <= bus.cmd_addr;
                        pwdata_q <= bus.cmd_wdata;
                        psel_q   <= 1'b1;
                        busy_q   <= 1'b1;
                        state_q  <= StSetup;
                    end
                end
                StSetup: begin
                    penable_q <= 1'b1;
                    wait_q    <= '0;
                    state_q   <= StAccess;
                end
                StAccess: begin
                    // A late pready wins over a simultaneous abort.
                    if (bus.pready) begin
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                        busy_q        <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_slverr_q  <= bus.pslverr;
                        rsp_rdata_q   <= (!pwrite_q && !bus.pslverr) ? bus.prdata : '0;
                        rsp_timeout_q <= 1'b0;
                        state_q       <= StIdle;
                    end else if (timeout_hit) begin
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                        busy_q        <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_slverr_q  <= 1'b0;
                        rsp_rdata_q   <= '0;
                        rsp_timeout_q <= 1'b1;
                        state_q       <= StIdle;
                    end else if (wait_q != CNT_MAX) begin
                        wait_q <= wait_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end
endmodule
